// File: rtl/buyruk_bellek_yanitlayici.sv
// Instruction memory responder: fixed-latency word reads behind a
// valid/ready fetch port, with a credit-limited in-order response queue.
module buyruk_bellek_yanitlayici #(
    parameter int ADRES_BIT       = 32,
    parameter int VERI_BIT        = 32,
    parameter int BELLEK_DERINLIK = 1024,
    parameter int GECIKME         = 2,
    parameter int KUYRUK_DERINLIK = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [ADRES_BIT-1:0] buyruk_istek_adres_i,
    input  logic                 buyruk_istek_gecerli_i,
    output logic                 buyruk_istek_hazir_o,
    output logic [VERI_BIT-1:0]  buyruk_yanit_veri_o,
    output logic                 buyruk_yanit_hata_o,
    output logic                 buyruk_yanit_gecerli_o,
    input  logic                 buyruk_yanit_hazir_i,
    input  logic [ADRES_BIT-1:0] yukle_adres_i,
    input  logic [VERI_BIT-1:0]  yukle_veri_i,
    input  logic                 yukle_gecerli_i,
    output logic [31:0]          tamamlanan_sayac_o
);

    localparam int AW = $clog2(BELLEK_DERINLIK);
    localparam int PW = $clog2(KUYRUK_DERINLIK);
    localparam int BW = PW + 1;
    localparam logic [BW-1:0] KAPASITE = BW'(KUYRUK_DERINLIK);

    logic [VERI_BIT-1:0] r_bellek [BELLEK_DERINLIK];

    logic [GECIKME-1:0]  r_hat_gecerli;
    logic [GECIKME-1:0]  r_hat_hata;
    logic [VERI_BIT-1:0] r_hat_veri [GECIKME];

    logic [VERI_BIT-1:0]        r_kuyruk_veri [KUYRUK_DERINLIK];
    logic [KUYRUK_DERINLIK-1:0] r_kuyruk_hata;
    logic [PW:0]                r_yaz;
    logic [PW:0]                r_oku;

    logic [BW-1:0] r_bekleyen;
    logic [31:0]   r_sayac;

    logic          w_istek_al;
    logic          w_yanit_al;
    logic          w_bos;
    logic          w_itme;
    logic          w_istek_disi;
    logic          w_istek_hizasiz;
    logic [AW-1:0] w_istek_idx;
    logic          w_yukle_disi;
    logic          w_yukle_yaz;
    logic [AW-1:0] w_yukle_idx;
    logic [VERI_BIT-1:0] w_oku_veri;
    logic [VERI_BIT-1:0] w_yeni_veri;
    logic          w_yeni_hata;

    assign w_istek_idx     = buyruk_istek_adres_i[2 +: AW];
    assign w_istek_disi    = |buyruk_istek_adres_i[ADRES_BIT-1:AW+2];
    assign w_istek_hizasiz = |buyruk_istek_adres_i[1:0];

    assign w_yukle_idx  = yukle_adres_i[2 +: AW];
    assign w_yukle_disi = |yukle_adres_i[ADRES_BIT-1:AW+2];
    assign w_yukle_yaz  = yukle_gecerli_i && !w_yukle_disi
                          && (yukle_adres_i[1:0] == 2'b00);

    // A preload landing on the same word in the same cycle wins the read.
    assign w_oku_veri = (w_yukle_yaz && (w_yukle_idx == w_istek_idx))
                        ? yukle_veri_i : r_bellek[w_istek_idx];
    assign w_yeni_veri = w_istek_disi ? '0 : w_oku_veri;
    assign w_yeni_hata = w_istek_disi || w_istek_hizasiz;

    assign w_bos  = (r_yaz == r_oku);
    assign w_itme = r_hat_gecerli[GECIKME-1];

    assign buyruk_istek_hazir_o   = !rst_i && (r_bekleyen < KAPASITE);
    assign buyruk_yanit_gecerli_o = !rst_i && !w_bos;
    assign buyruk_yanit_veri_o    = w_bos ? '0
                                    : r_kuyruk_veri[r_oku[PW-1:0]];
    assign buyruk_yanit_hata_o    = w_bos ? 1'b0
                                    : r_kuyruk_hata[r_oku[PW-1:0]];
    assign tamamlanan_sayac_o     = r_sayac;

    assign w_istek_al = buyruk_istek_gecerli_i && buyruk_istek_hazir_o;
    assign w_yanit_al = buyruk_yanit_gecerli_o && buyruk_yanit_hazir_i;

    always_ff @(posedge clk_i) begin
        if (w_yukle_yaz) begin
            r_bellek[w_yukle_idx] <= yukle_veri_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_hat_gecerli <= '0;
        end else begin
            r_hat_gecerli[0] <= w_istek_al;
            for (int i = 1; i < GECIKME; i++) begin
                r_hat_gecerli[i] <= r_hat_gecerli[i-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        r_hat_veri[0] <= w_yeni_veri;
        r_hat_hata[0] <= w_yeni_hata;
        for (int i = 1; i < GECIKME; i++) begin
            r_hat_veri[i] <= r_hat_veri[i-1];
            r_hat_hata[i] <= r_hat_hata[i-1];
        end
    end

    // Credits guarantee the queue has room whenever the pipe pushes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_yaz <= '0;
            r_oku <= '0;
        end else begin
            if (w_itme) begin
                r_yaz <= r_yaz + 1'b1;
            end
            if (w_yanit_al) begin
                r_oku <= r_oku + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_itme) begin
            r_kuyruk_veri[r_yaz[PW-1:0]] <= r_hat_veri[GECIKME-1];
            r_kuyruk_hata[r_yaz[PW-1:0]] <= r_hat_hata[GECIKME-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_bekleyen <= '0;
        end else if (w_istek_al && !w_yanit_al) begin
            r_bekleyen <= r_bekleyen + 1'b1;
        end else if (!w_istek_al && w_yanit_al) begin
            r_bekleyen <= r_bekleyen - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sayac <= '0;
        end else if (w_yanit_al) begin
            r_sayac <= r_sayac + 32'd1;
        end
    end

endmodule

// File: tb/tb_buyruk_bellek_yanitlayici.sv
// Bench for buyruk_bellek_yanitlayici: directed scenarios then random
// traffic, scored against a queue-based reference model.
module tb_buyruk_bellek_yanitlayici;

    localparam int D = 1024;
    localparam int G = 2;
    localparam int K = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ia;
    logic        iv;
    logic        ih;
    logic [31:0] yv;
    logic        yh;
    logic        yg;
    logic        yr;
    logic [31:0] ya;
    logic [31:0] yd;
    logic        yw;
    logic [31:0] cnt;

    always #5 clk = ~clk;

    buyruk_bellek_yanitlayici #(
        .ADRES_BIT(32), .VERI_BIT(32), .BELLEK_DERINLIK(D),
        .GECIKME(G), .KUYRUK_DERINLIK(K)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .buyruk_istek_adres_i(ia),
        .buyruk_istek_gecerli_i(iv),
        .buyruk_istek_hazir_o(ih),
        .buyruk_yanit_veri_o(yv),
        .buyruk_yanit_hata_o(yh),
        .buyruk_yanit_gecerli_o(yg),
        .buyruk_yanit_hazir_i(yr),
        .yukle_adres_i(ya),
        .yukle_veri_i(yd),
        .yukle_gecerli_i(yw),
        .tamamlanan_sayac_o(cnt)
    );

    typedef struct {
        logic [31:0] veri;
        logic        hata;
        longint      hazir;
    } yanit_t;

    yanit_t      q[$];
    logic [31:0] mem [D];
    longint      kenar;
    int          tests;
    int          fails;
    logic [31:0] exp_cnt;
    bit          acc;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs vs model at negedge, then advance the model
    // with the handshakes and preload that happen on the rising edge.
    task automatic cyc();
        logic   eh, ev, ra, pa, wr_ok;
        yanit_t e;
        int     idx;
        e.veri = 0;
        e.hata = 0;
        e.hazir = 0;
        @(negedge clk);
        eh = !rst && (q.size() < K);
        ev = !rst && (q.size() > 0) && (q[0].hazir <= kenar);
        chk("istek_hazir", 32'(ih), 32'(eh));
        chk("yanit_gecerli", 32'(yg), 32'(ev));
        chk("sayac", cnt, exp_cnt);
        ra = iv && eh;
        pa = ev && yr;
        if (pa) begin
            chk("yanit_veri", yv, q[0].veri);
            chk("yanit_hata", 32'(yh), 32'(q[0].hata));
        end
        acc = ra;
        wr_ok = yw && (ya < 4 * D) && (ya % 4 == 0);
        if (ra) begin
            if (ia >= 4 * D) begin
                e.veri = 0;
                e.hata = 1;
            end else begin
                idx = int'(ia / 4);
                e.veri = (wr_ok && (ya / 4 == ia / 4)) ? yd : mem[idx];
                e.hata = (ia % 4 != 0);
            end
            e.hazir = kenar + 1 + G;
        end
        @(posedge clk);
        kenar++;
        if (rst) begin
            q.delete();
            exp_cnt = 0;
        end else begin
            if (pa) begin
                void'(q.pop_front());
                exp_cnt++;
            end
            if (ra) q.push_back(e);
        end
        if (wr_ok) mem[ya / 4] = yd;
        #1;
    endtask

    task automatic istek(logic [31:0] a);
        int n;
        ia = a;
        iv = 1'b1;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!acc && n < 50);
        tests++;
        assert (acc) else begin
            fails++;
            $error("FAIL istek_kabul: observed none expected accept of %h", a);
        end
        iv = 1'b0;
    endtask

    task automatic yukle(logic [31:0] a, logic [31:0] d);
        ya = a;
        yd = d;
        yw = 1'b1;
        cyc();
        yw = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        kenar = 0;
        exp_cnt = 0;
        acc = 0;
        rst = 1'b1;
        iv = 1'b0;
        ia = 0;
        yr = 1'b0;
        ya = 0;
        yd = 0;
        yw = 1'b0;
        @(posedge clk);
        #1;
        repeat (2) cyc();
        rst = 1'b0;
        cyc();
        chk("bos_veri", yv, 32'h0);
        chk("bos_hata", 32'(yh), 32'h0);

        // Preload a working set plus word 0x100 for the misaligned case.
        for (int i = 0; i < 64; i++) yukle(32'(i * 4), $urandom);
        yukle(32'h400, 32'hA5A5_0400);

        // Single fetch.
        yukle(32'h0, 32'h0010_8093);
        yr = 1'b1;
        istek(32'h0);
        repeat (4) cyc();
        chk("tek_sayac", cnt, 32'd1);

        // Streaming.
        for (int i = 0; i < 6; i++) yukle(32'(i * 4), 32'h0010_8093);
        for (int i = 0; i < 6; i++) istek(32'(i * 4));
        repeat (6) cyc();
        chk("akis_sayac", cnt, 32'd7);

        // Backpressure.
        yr = 1'b0;
        iv = 1'b1;
        ia = 32'h10;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (acc) ia = ia + 4;
        end
        yr = 1'b1;
        cyc();
        if (acc) ia = ia + 4;
        yr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (acc) ia = ia + 4;
        end
        iv = 1'b0;
        yr = 1'b1;
        repeat (12) cyc();

        // Error responses.
        istek(32'h402);
        istek(32'h1000);
        istek(32'h1002);
        repeat (6) cyc();

        // Write-first.
        ya = 32'hC;
        yd = 32'hDEAD_BEEF;
        yw = 1'b1;
        istek(32'hC);
        yw = 1'b0;
        repeat (6) cyc();

        // Mid-operation reset.
        yr = 1'b0;
        istek(32'h0);
        istek(32'h4);
        istek(32'h8);
        rst = 1'b1;
        cyc();
        chk("rst_sayac", cnt, 32'h0);
        rst = 1'b0;
        yr = 1'b1;
        repeat (8) cyc();
        istek(32'h0);
        repeat (5) cyc();

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            yr = ($urandom % 4) != 0;
            yw = ($urandom % 4) == 0;
            case ($urandom % 8)
                0: ya = $urandom | 32'h1000;
                1: ya = ($urandom % 64) * 4 + 1 + ($urandom % 3);
                default: ya = ($urandom % 64) * 4;
            endcase
            yd = $urandom;
            if (!iv || acc) begin
                iv = ($urandom % 3) != 0;
                case ($urandom % 10)
                    0: ia = $urandom | 32'h1000;
                    1: ia = ($urandom % 64) * 4 + 1 + ($urandom % 3);
                    default: ia = ($urandom % 64) * 4;
                endcase
            end
            rst = ($urandom % 250) == 0;
            cyc();
        end
        rst = 1'b0;
        iv = 1'b0;
        yw = 1'b0;
        yr = 1'b1;
        repeat (12) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
